// File: rtl/led_status_ctrl.sv
// Registered LED driver for the ALU board: captures result/flags on Valid,
// accumulates sticky flags, and displays result, flags, rotate or overflow-blink.
module led_status_ctrl #(
    parameter int WIDTH     = 4,
    parameter int NFLAGS    = 4,
    parameter int BLINK_DIV = 25_000_000,
    parameter int ROT_DIV   = 50_000_000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  FuncIn,
    input  logic [NFLAGS-1:0] FlagsIn,
    input  logic              Valid,
    input  logic              Clear,
    input  logic [1:0]        Mode,
    output logic [WIDTH-1:0]  Out,
    output logic [NFLAGS-1:0] Sticky
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int RW = $clog2(ROT_DIV);

    localparam logic [1:0] MODE_RESULT = 2'd0;
    localparam logic [1:0] MODE_FLAGS  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [RW-1:0] ROT_LAST   = RW'(ROT_DIV - 1);

    logic [WIDTH-1:0] res_reg;
    logic [BW-1:0]    blink_cnt;
    logic             blink_ph;
    logic [RW-1:0]    rot_cnt;
    logic             rot_ph;
    logic [WIDTH-1:0] flags_ext;
    logic [WIDTH-1:0] out_next;

    always_comb begin
        flags_ext               = '0;
        flags_ext[NFLAGS-1:0]   = Sticky;
    end

    always_comb begin
        out_next = res_reg;
        case (Mode)
            MODE_RESULT: out_next = res_reg;
            MODE_FLAGS:  out_next = flags_ext;
            MODE_ROTATE: out_next = rot_ph ? flags_ext : res_reg;
            MODE_BLINK:  out_next = (Sticky[0] && blink_ph) ? '0 : res_reg;
            default:     out_next = res_reg;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_reg   <= '0;
            Sticky    <= '0;
            Out       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            rot_cnt   <= '0;
            rot_ph    <= 1'b0;
        end else begin
            if (Valid)
                res_reg <= FuncIn;

            // Clear together with Valid means clear-then-capture.
            if (Clear && Valid)
                Sticky <= FlagsIn;
            else if (Clear)
                Sticky <= '0;
            else if (Valid)
                Sticky <= Sticky | FlagsIn;

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            // Outside rotate mode the timer is parked so rotation starts on the result.
            if (Mode != MODE_ROTATE) begin
                rot_cnt <= '0;
                rot_ph  <= 1'b0;
            end else if (rot_cnt == ROT_LAST) begin
                rot_cnt <= '0;
                rot_ph  <= ~rot_ph;
            end else begin
                rot_cnt <= rot_cnt + RW'(1);
            end

            Out <= out_next;
        end
    end

endmodule
